// File: rtl/icache_pkg.sv
// icache_pkg: shared types, default sizes and refill address helper for the I-cache refill controller
package icache_pkg;
  localparam int DEF_ADDR_SIZE = 14;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_LINES_PER_SET = 32;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int OFF_BITS = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX_BITS = $clog2(DEF_LINES_PER_SET);
  localparam int TAG_BITS = DEF_ADDR_SIZE - IDX_BITS - OFF_BITS;
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_e;
  function automatic logic [31:0] refill_addr(input logic [31:0] base, input logic [31:0] off, input int unsigned off_bits);
    return (base << off_bits) | off;
  endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch, L1 write port, memory read port and miss counter bundle
interface icache_refill_ctrl_if #(
  parameter int ADDR_SIZE = 14,
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 fetch_en;
  logic [ADDR_SIZE-1:0] fetch_addr;
  logic                 cache_hit;
  logic                 cache_we;
  logic [ADDR_SIZE-1:0] cache_addr;
  logic [WORD_SIZE-1:0] cache_data;
  logic                 stall;
  logic                 mem_rd;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_valid;
  logic [CNT_WIDTH-1:0] miss_count;
  modport master (
    input  fetch_en, fetch_addr, cache_hit, mem_rdata, mem_valid,
    output cache_we, cache_addr, cache_data, stall, mem_rd, mem_addr, miss_count
  );
  modport slave (
    output fetch_en, fetch_addr, cache_hit, mem_rdata, mem_valid,
    input  cache_we, cache_addr, cache_data, stall, mem_rd, mem_addr, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones, async active-low clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: stalls fetch on an L1 miss and refills the line word by word from memory
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int LINES_PER_SET  = DEF_LINES_PER_SET,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic reset,
  icache_refill_ctrl_if.master bus
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  if (ADDR_SIZE < OW + $clog2(LINES_PER_SET)) begin : g_bad_geometry
    $error("address too narrow for index and offset");
  end
  state_e                  state_q, state_d;
  logic [OW-1:0]           off_q, off_d;
  logic [ADDR_SIZE-OW-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0]    data_q, data_d;
  logic                    we_q, rd_q, miss, last;
  logic [ADDR_SIZE-1:0]    rf_addr;
  assign rf_addr = ADDR_SIZE'(refill_addr(32'(base_q), 32'(off_q), OW));
  assign miss = state_q == IDLE && bus.fetch_en && !bus.cache_hit;
  assign last = off_q == OW'(WORDS_PER_LINE - 1);
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    base_d = base_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (miss) begin
        state_d = REQ;
        off_d = '0;
        base_d = bus.fetch_addr[ADDR_SIZE-1:OW];
      end
      REQ: if (bus.mem_valid) begin
        state_d = WRITE;
        data_d = bus.mem_rdata;
      end
      WRITE: begin
        state_d = last ? DONE : REQ;
        off_d = last ? off_q : off_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      off_q <= '0;
      base_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      base_q <= base_d;
      data_q <= data_d;
      we_q <= state_d == WRITE;
      rd_q <= state_d == REQ;
    end
  // The L1 sees the fetch address whenever no refill word is in flight
  assign bus.cache_addr = (state_q == IDLE || state_q == DONE) ? bus.fetch_addr : rf_addr;
  assign bus.mem_addr = rf_addr;
  assign bus.stall = state_q != IDLE || (bus.fetch_en && !bus.cache_hit);
  assign bus.cache_we = we_q;
  assign bus.cache_data = data_q;
  assign bus.mem_rd = rd_q;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk),
    .clr_n(reset),
    .en_i(miss),
    .cnt_o(bus.miss_count)
  );
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench with an L1 valid model and a variable-latency memory
module tb_icache_refill_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  int lat = 0;
  int wcnt = 0;
  bit line_v [2048];
  logic [45:0] exp_q [$];
  icache_refill_ctrl_if bus ();
  icache_refill_ctrl_if #(.CNT_WIDTH(2)) bus2 ();
  icache_refill_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  icache_refill_ctrl #(.CNT_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;
  always_ff @(posedge clk) wcnt <= (bus.mem_rd && !bus.mem_valid) ? wcnt + 1 : 0;
  assign bus.mem_valid = bus.mem_rd && wcnt >= lat;
  assign bus.mem_rdata = 32'hA000_0000 + 32'(bus.mem_addr[2:0]);
  assign bus.cache_hit = line_v[bus.cache_addr[13:3]];
  assign bus2.fetch_en = bus.fetch_en;
  assign bus2.fetch_addr = bus.fetch_addr;
  assign bus2.cache_hit = bus.cache_hit;
  assign bus2.mem_valid = bus.mem_valid;
  assign bus2.mem_rdata = bus.mem_rdata;
  // L1 model: samples the write port on the falling edge, validates on the last word
  always @(negedge clk) if (bus.cache_we && bus.cache_addr[2:0] == 3'd7) line_v[bus.cache_addr[13:3]] = 1'b1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic        prev_rd = 1'b0, prev_valid = 1'b0;
  logic [13:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    if (reset && bus.cache_we) begin
      if (exp_q.size() == 0) check("extra_we", {18'd0, bus.cache_addr, bus.cache_data}, 64'd0);
      else begin
        logic [45:0] e;
        e = exp_q.pop_front();
        check("we_addr", 64'(bus.cache_addr), 64'(e[45:32]));
        check("we_data", 64'(bus.cache_data), 64'(e[31:0]));
      end
    end
    if (reset && prev_rd && !prev_valid && bus.mem_rd) check("mem_addr_hold", 64'(bus.mem_addr), 64'(prev_addr));
    prev_rd = bus.mem_rd;
    prev_valid = bus.mem_valid;
    prev_addr = bus.mem_addr;
  end
  task automatic push_line(input logic [13:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a[13:3], 3'(i), 32'hA000_0000 + 32'(i)});
  endtask
  task automatic miss_run(input logic [13:0] a, input int exp_st, input string nm);
    int n = 0;
    @(posedge clk);
    #1 bus.fetch_en = 1'b1;
    bus.fetch_addr = a;
    @(negedge clk);
    while (bus.stall && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_stall_cycles"}, 64'(n), 64'(exp_st));
    check({nm, "_hit_after"}, 64'(bus.cache_hit), 64'd1);
    check({nm, "_words_left"}, 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int n;
    bus.fetch_en = 1'b0;
    bus.fetch_addr = '0;
    #1;
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("rst_we", 64'(bus.cache_we), 64'd0);
    check("rst_count", 64'(bus.miss_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    // Reset while waiting for word 3 of a refill
    lat = 3;
    push_line(14'h0123, 3);
    @(posedge clk);
    #1 bus.fetch_en = 1'b1;
    bus.fetch_addr = 14'h0123;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_rd && bus.mem_addr == 14'h0123) && n < 200);
    check("reach_off3", 64'(n < 200), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_mem_rd", 64'(bus.mem_rd), 64'd0);
    check("arst_we", 64'(bus.cache_we), 64'd0);
    check("arst_count", 64'(bus.miss_count), 64'd0);
    check("arst_idle_addr", 64'(bus.cache_addr), 64'h0123);
    check("arst_idle_stall", 64'(bus.stall), 64'd1);
    bus.fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("arst_words_left", 64'(exp_q.size()), 64'd0);
    // Cold miss, zero-wait memory
    lat = 0;
    push_line(14'h0123, 8);
    miss_run(14'h0123, 18, "cold");
    check("cold_count", 64'(bus.miss_count), 64'd1);
    // Hit in the refilled line
    @(posedge clk);
    #1 bus.fetch_addr = 14'h0124;
    @(negedge clk);
    check("hit_stall", 64'(bus.stall), 64'd0);
    check("hit_mem_rd", 64'(bus.mem_rd), 64'd0);
    @(negedge clk);
    check("hit_count", 64'(bus.miss_count), 64'd1);
    // Same miss with three wait cycles per word
    bus.fetch_en = 1'b0;
    line_v[11'h024] = 1'b0;
    lat = 3;
    push_line(14'h0123, 8);
    miss_run(14'h0123, 42, "slow");
    check("slow_count", 64'(bus.miss_count), 64'd2);
    // PC moves to another line mid-refill
    bus.fetch_en = 1'b0;
    line_v[11'h024] = 1'b0;
    lat = 0;
    push_line(14'h0123, 8);
    push_line(14'h0200, 8);
    fork
      begin
        repeat (6) @(posedge clk);
        #1 bus.fetch_addr = 14'h0200;
      end
    join_none
    miss_run(14'h0123, 36, "pcmove");
    check("pcmove_addr", 64'(bus.cache_addr), 64'h0200);
    check("pcmove_count", 64'(bus.miss_count), 64'd4);
    check("pcmove_count2", 64'(bus2.miss_count), 64'd3);
    // Fresh reset, then five misses to distinct lines
    bus.fetch_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push_line(14'h0300 + 14'(8 * (k - 1)), 8);
      miss_run(14'h0300 + 14'(8 * (k - 1)), 18, "sat");
      check("sat_count16", 64'(bus.miss_count), 64'(k));
      check("sat_count2", 64'(bus2.miss_count), 64'(k > 3 ? 3 : k));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
